// File: rtl/mkmif_burst.sv
// Burst sequencer for the MKM interface core: expands one (mode, address, count)
// command into single-word read/write/init operations on the core op/ready handshake.
module mkmif_burst #(
    parameter int CNT_WIDTH = 12
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cmd_start,
    input  logic [1:0]           cmd_mode,
    input  logic [15:0]          cmd_addr,
    input  logic [CNT_WIDTH-1:0] cmd_words,
    output logic                 busy,
    output logic                 done,
    input  logic [31:0]          wr_data,
    input  logic                 wr_valid,
    output logic                 wr_ready,
    output logic [31:0]          rd_data,
    output logic                 rd_valid,
    input  logic                 rd_ready,
    output logic                 mkm_read_op,
    output logic                 mkm_write_op,
    output logic                 mkm_init_op,
    input  logic                 mkm_ready,
    output logic [15:0]          mkm_addr,
    output logic [31:0]          mkm_write_data,
    input  logic [31:0]          mkm_read_data
);

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_ISSUE     = 3'd1;
    localparam logic [2:0] ST_WAIT_ACK  = 3'd2;
    localparam logic [2:0] ST_WAIT_DONE = 3'd3;
    localparam logic [2:0] ST_FINISH    = 3'd4;

    localparam logic [1:0] MODE_READ  = 2'b00;
    localparam logic [1:0] MODE_WRITE = 2'b01;
    localparam logic [1:0] MODE_ZERO  = 2'b10;
    localparam logic [1:0] MODE_INIT  = 2'b11;

    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = CNT_WIDTH'(0);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

    logic [2:0]           state_q, state_d;
    logic [1:0]           mode_q, mode_d;
    logic [15:0]          addr_q, addr_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 wr_ready_q, wr_ready_d;
    logic                 rd_valid_q, rd_valid_d;
    logic [31:0]          rd_data_q, rd_data_d;
    logic                 read_op_q, read_op_d;
    logic                 write_op_q, write_op_d;
    logic                 init_op_q, init_op_d;
    logic [15:0]          mkm_addr_q, mkm_addr_d;
    logic [31:0]          wdata_q, wdata_d;
    logic                 issue_ok_s;

    // Next-state and output computation for the burst sequencer.
    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        addr_d     = addr_q;
        cnt_d      = cnt_q;
        done_d     = 1'b0;
        wr_ready_d = 1'b0;
        rd_data_d  = rd_data_q;
        read_op_d  = 1'b0;
        write_op_d = 1'b0;
        init_op_d  = 1'b0;
        mkm_addr_d = mkm_addr_q;
        wdata_d    = wdata_q;

        // Consumer handshake retires the read beat regardless of state.
        if (rd_valid_q && rd_ready) begin
            rd_valid_d = 1'b0;
        end else begin
            rd_valid_d = rd_valid_q;
        end

        issue_ok_s = mkm_ready
                     && !((mode_q == MODE_WRITE) && !wr_valid)
                     && !((mode_q == MODE_READ) && rd_valid_q);

        case (state_q)
            ST_IDLE: begin
                if (cmd_start) begin
                    mode_d = cmd_mode;
                    addr_d = cmd_addr;
                    cnt_d  = cmd_words;
                    if ((cmd_mode != MODE_INIT) && (cmd_words == CNT_ZERO)) begin
                        state_d = ST_FINISH;
                    end else begin
                        state_d = ST_ISSUE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (issue_ok_s) begin
                    mkm_addr_d = addr_q;
                    state_d    = ST_WAIT_ACK;
                    case (mode_q)
                        MODE_READ: begin
                            read_op_d = 1'b1;
                        end
                        MODE_WRITE: begin
                            write_op_d = 1'b1;
                            wr_ready_d = 1'b1;
                            wdata_d    = wr_data;
                        end
                        MODE_ZERO: begin
                            write_op_d = 1'b1;
                            wdata_d    = 32'h0000_0000;
                        end
                        default: begin
                            init_op_d = 1'b1;
                        end
                    endcase
                end else begin
                    state_d = ST_ISSUE;
                end
            end
            ST_WAIT_ACK: begin
                if (!mkm_ready) begin
                    state_d = ST_WAIT_DONE;
                end else begin
                    state_d = ST_WAIT_ACK;
                end
            end
            ST_WAIT_DONE: begin
                if (mkm_ready) begin
                    if (mode_q == MODE_READ) begin
                        rd_data_d  = mkm_read_data;
                        rd_valid_d = 1'b1;
                    end else begin
                        rd_data_d  = rd_data_q;
                    end
                    cnt_d  = cnt_q - CNT_ONE;
                    addr_d = addr_q + 16'd4;
                    if ((mode_q == MODE_INIT) || (cnt_q == CNT_ONE)) begin
                        state_d = ST_FINISH;
                    end else begin
                        state_d = ST_ISSUE;
                    end
                end else begin
                    state_d = ST_WAIT_DONE;
                end
            end
            ST_FINISH: begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and registered-output flops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            mode_q     <= 2'b00;
            addr_q     <= 16'h0000;
            cnt_q      <= CNT_ZERO;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            wr_ready_q <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= 32'h0000_0000;
            read_op_q  <= 1'b0;
            write_op_q <= 1'b0;
            init_op_q  <= 1'b0;
            mkm_addr_q <= 16'h0000;
            wdata_q    <= 32'h0000_0000;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            wr_ready_q <= wr_ready_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            read_op_q  <= read_op_d;
            write_op_q <= write_op_d;
            init_op_q  <= init_op_d;
            mkm_addr_q <= mkm_addr_d;
            wdata_q    <= wdata_d;
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign wr_ready       = wr_ready_q;
    assign rd_valid       = rd_valid_q;
    assign rd_data        = rd_data_q;
    assign mkm_read_op    = read_op_q;
    assign mkm_write_op   = write_op_q;
    assign mkm_init_op    = init_op_q;
    assign mkm_addr       = mkm_addr_q;
    assign mkm_write_data = wdata_q;

endmodule

// File: tb/tb_mkmif_burst.sv
// Directed bench for mkmif_burst with a small MKM core model (3-cycle turnaround,
// word-addressed memory) and negedge monitors for ops, stream beats and done.
module tb_mkmif_burst;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_start;
    logic [1:0]  cmd_mode;
    logic [15:0] cmd_addr;
    logic [11:0] cmd_words;
    logic        busy, done;
    logic [31:0] wr_data;
    logic        wr_valid, wr_ready;
    logic [31:0] rd_data;
    logic        rd_valid, rd_ready;
    logic        mkm_read_op, mkm_write_op, mkm_init_op;
    logic        mkm_ready;
    logic [15:0] mkm_addr;
    logic [31:0] mkm_write_data, mkm_read_data;

    mkmif_burst #(.CNT_WIDTH(12)) dut (
        .clk(clk), .reset(reset),
        .cmd_start(cmd_start), .cmd_mode(cmd_mode), .cmd_addr(cmd_addr), .cmd_words(cmd_words),
        .busy(busy), .done(done),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .mkm_read_op(mkm_read_op), .mkm_write_op(mkm_write_op), .mkm_init_op(mkm_init_op),
        .mkm_ready(mkm_ready), .mkm_addr(mkm_addr),
        .mkm_write_data(mkm_write_data), .mkm_read_data(mkm_read_data)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int n_rd_op = 0, n_wr_op = 0, n_init_op = 0, n_wr_rdy = 0, done_cnt = 0, bad_op = 0;
    int core_left = 0;
    logic core_hold = 1'b0;
    logic op_any;
    logic [1:0]  c_kind;
    logic [15:0] c_addr;
    logic [31:0] c_wdata;
    logic [31:0] mem [0:16383];
    logic [15:0] addr_log [$];
    logic [31:0] rd_log [$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic send_cmd(input logic [1:0] m, input logic [15:0] a, input logic [11:0] n);
        cmd_mode  = m;
        cmd_addr  = a;
        cmd_words = n;
        cmd_start = 1'b1;
        @(posedge clk); #1;
        cmd_start = 1'b0;
    endtask

    task automatic wait_done(input int base, input string tag);
        int n;
        n = 0;
        while (done_cnt == base && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq({tag, "_done_in_time"}, 32'(done_cnt != base), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_busy"}, 32'(busy), 32'd0);
        check_eq({tag, "_done"}, 32'(done), 32'd0);
        check_eq({tag, "_wr_ready"}, 32'(wr_ready), 32'd0);
        check_eq({tag, "_rd_valid"}, 32'(rd_valid), 32'd0);
        check_eq({tag, "_ops"}, 32'({mkm_read_op, mkm_write_op, mkm_init_op}), 32'd0);
        check_eq({tag, "_mkm_addr"}, 32'(mkm_addr), 32'd0);
        check_eq({tag, "_wdata"}, mkm_write_data, 32'd0);
        check_eq({tag, "_rd_data"}, rd_data, 32'd0);
    endtask

    // Core model plus monitors, all evaluated on the falling edge.
    initial begin
        mkm_ready     = 1'b1;
        mkm_read_data = 32'h0;
        forever begin
            @(negedge clk);
            op_any = mkm_read_op | mkm_write_op | mkm_init_op;
            if (op_any) begin
                if (!mkm_ready || core_left != 0) bad_op++;
                if ((32'(mkm_read_op) + 32'(mkm_write_op) + 32'(mkm_init_op)) != 32'd1) bad_op++;
                if (mkm_read_op)  n_rd_op++;
                if (mkm_write_op) n_wr_op++;
                if (mkm_init_op)  n_init_op++;
                addr_log.push_back(mkm_addr);
            end
            if (wr_ready) n_wr_rdy++;
            if (done) done_cnt++;
            if (rd_valid && rd_ready) rd_log.push_back(rd_data);
            if (reset) begin
                core_left = 0;
                mkm_ready = !core_hold;
            end else if (core_left > 0) begin
                core_left--;
                if (core_left == 0) begin
                    if (c_kind == 2'd1) mem[c_addr[15:2]] = c_wdata;
                    else if (c_kind == 2'd0) mkm_read_data = mem[c_addr[15:2]];
                    mkm_ready = 1'b1;
                end
            end else if (op_any) begin
                mkm_ready = 1'b0;
                core_left = 3;
                c_addr    = mkm_addr;
                c_wdata   = mkm_write_data;
                c_kind    = mkm_read_op ? 2'd0 : (mkm_write_op ? 2'd1 : 2'd2);
            end else begin
                mkm_ready = !core_hold;
            end
        end
    end

    initial begin
        int base, b_rd, b_wr, b_init, b_wrdy, n;
        for (int i = 0; i < 16384; i++) mem[i] = 32'h0;
        reset = 1'b1; cmd_start = 1'b0; cmd_mode = 2'b00; cmd_addr = 16'h0; cmd_words = 12'h0;
        wr_data = 32'h0; wr_valid = 1'b0; rd_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        reset = 1'b0;
        @(posedge clk); #1;

        // Read burst, free-flowing consumer.
        mem[4] = 32'h1111_0001; mem[5] = 32'h2222_0002; mem[6] = 32'h3333_0003;
        rd_ready = 1'b1; addr_log.delete(); rd_log.delete();
        base = done_cnt;
        send_cmd(2'b00, 16'h0010, 12'd3);
        check_eq("rd_busy_rise", 32'(busy), 32'd1);
        wait_done(base, "rd");
        repeat (3) @(posedge clk);
        #1;
        check_eq("rd_one_done", 32'(done_cnt - base), 32'd1);
        check_eq("rd_busy_low", 32'(busy), 32'd0);
        check_eq("rd_n_addr", 32'(addr_log.size()), 32'd3);
        check_eq("rd_addr0", 32'(addr_log[0]), 32'h0010);
        check_eq("rd_addr1", 32'(addr_log[1]), 32'h0014);
        check_eq("rd_addr2", 32'(addr_log[2]), 32'h0018);
        check_eq("rd_n_beats", 32'(rd_log.size()), 32'd3);
        check_eq("rd_beat0", rd_log[0], 32'h1111_0001);
        check_eq("rd_beat1", rd_log[1], 32'h2222_0002);
        check_eq("rd_beat2", rd_log[2], 32'h3333_0003);

        // Write burst with a stalling producer.
        base = done_cnt; b_wrdy = n_wr_rdy; b_wr = n_wr_op;
        wr_data = 32'hDEAD_BEEF; wr_valid = 1'b1;
        send_cmd(2'b01, 16'h0100, 12'd2);
        n = 0;
        while (n_wr_rdy != b_wrdy + 1 && n < 100) begin @(posedge clk); #1; n++; end
        check_eq("wr_first_accept", 32'(n_wr_rdy - b_wrdy), 32'd1);
        wr_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check_eq("wr_no_op_while_invalid", 32'(n_wr_op - b_wr), 32'd1);
        check_eq("wr_wdata_stable", mkm_write_data, 32'hDEAD_BEEF);
        wr_data = 32'h0123_4567; wr_valid = 1'b1;
        n = 0;
        while (n_wr_rdy != b_wrdy + 2 && n < 100) begin @(posedge clk); #1; n++; end
        wr_valid = 1'b0;
        wait_done(base, "wr");
        repeat (3) @(posedge clk);
        #1;
        check_eq("wr_mem0", mem[16'h0100 >> 2], 32'hDEAD_BEEF);
        check_eq("wr_mem1", mem[16'h0104 >> 2], 32'h0123_4567);
        check_eq("wr_ready_pulses", 32'(n_wr_rdy - b_wrdy), 32'd2);

        // Zeroize across the address wrap; the write stream must stay untouched.
        mem[16382] = 32'hAAAA_0001; mem[16383] = 32'hAAAA_0002; mem[0] = 32'hAAAA_0003; mem[1] = 32'hAAAA_0004;
        addr_log.delete();
        base = done_cnt; b_wrdy = n_wr_rdy; b_wr = n_wr_op;
        wr_data = 32'hFFFF_FFFF; wr_valid = 1'b1;
        send_cmd(2'b10, 16'hFFF8, 12'd4);
        wait_done(base, "zero");
        wr_valid = 1'b0;
        check_eq("zero_n_ops", 32'(n_wr_op - b_wr), 32'd4);
        check_eq("zero_addr0", 32'(addr_log[0]), 32'hFFF8);
        check_eq("zero_addr1", 32'(addr_log[1]), 32'hFFFC);
        check_eq("zero_addr2", 32'(addr_log[2]), 32'h0000);
        check_eq("zero_addr3", 32'(addr_log[3]), 32'h0004);
        check_eq("zero_mem", mem[16382] | mem[16383] | mem[0] | mem[1], 32'h0);
        check_eq("zero_no_wr_ready", 32'(n_wr_rdy - b_wrdy), 32'd0);

        // Read backpressure.
        mem[32] = 32'hB000_0000; mem[33] = 32'hB000_0001; mem[34] = 32'hB000_0002; mem[35] = 32'hB000_0003;
        rd_ready = 1'b0; rd_log.delete();
        base = done_cnt; b_rd = n_rd_op;
        send_cmd(2'b00, 16'h0080, 12'd4);
        repeat (20) @(posedge clk);
        #1;
        check_eq("bp_one_op", 32'(n_rd_op - b_rd), 32'd1);
        check_eq("bp_rd_valid", 32'(rd_valid), 32'd1);
        check_eq("bp_rd_data", rd_data, 32'hB000_0000);
        rd_ready = 1'b1;
        wait_done(base, "bp");
        repeat (3) @(posedge clk);
        #1;
        check_eq("bp_total_ops", 32'(n_rd_op - b_rd), 32'd4);
        check_eq("bp_n_beats", 32'(rd_log.size()), 32'd4);
        for (int i = 0; i < 4; i++) check_eq($sformatf("bp_beat%0d", i), rd_log[i], 32'hB000_0000 + 32'(i));

        // Zero count: done two cycles after cmd_start, a mid-command strobe is ignored.
        b_rd = n_rd_op; b_wr = n_wr_op; b_init = n_init_op;
        send_cmd(2'b00, 16'h0040, 12'd0);
        check_eq("zc_no_done_yet", 32'(done), 32'd0);
        cmd_mode = 2'b11; cmd_start = 1'b1;
        @(posedge clk); #1;
        cmd_start = 1'b0;
        check_eq("zc_done", 32'(done), 32'd1);
        check_eq("zc_busy_low", 32'(busy), 32'd0);
        repeat (5) @(posedge clk);
        #1;
        check_eq("zc_no_ops", 32'((n_rd_op - b_rd) + (n_wr_op - b_wr) + (n_init_op - b_init)), 32'd0);

        // Init: one op, then done; strobes while busy are ignored.
        base = done_cnt;
        send_cmd(2'b11, 16'h0040, 12'd0);
        cmd_mode = 2'b00; cmd_words = 12'd5; cmd_start = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        cmd_start = 1'b0;
        wait_done(base, "init");
        repeat (10) @(posedge clk);
        #1;
        check_eq("init_one_op", 32'(n_init_op - b_init), 32'd1);
        check_eq("init_no_other_ops", 32'((n_rd_op - b_rd) + (n_wr_op - b_wr)), 32'd0);
        check_eq("init_one_done", 32'(done_cnt - base), 32'd1);

        // Reset during WAIT_DONE of word 2 of 5, then recover with a busy core.
        for (int i = 0; i < 5; i++) mem[128 + i] = 32'hC000_0000 + 32'(i);
        mem[192] = 32'hCAFE_F00D;
        b_rd = n_rd_op; rd_ready = 1'b1;
        send_cmd(2'b00, 16'h0200, 12'd5);
        n = 0;
        while (n_rd_op != b_rd + 2 && n < 200) begin @(posedge clk); #1; n++; end
        check_eq("rst_reached_word2", 32'(n_rd_op - b_rd), 32'd2);
        core_hold = 1'b1; reset = 1'b1;
        #1;
        check_reset_outputs("midrst");
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        rd_log.delete();
        b_rd = n_rd_op; base = done_cnt;
        send_cmd(2'b00, 16'h0300, 12'd1);
        repeat (10) @(posedge clk);
        #1;
        check_eq("rst_no_op_core_busy", 32'(n_rd_op - b_rd), 32'd0);
        check_eq("rst_busy_waiting", 32'(busy), 32'd1);
        core_hold = 1'b0;
        wait_done(base, "rst_read");
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_one_op", 32'(n_rd_op - b_rd), 32'd1);
        check_eq("rst_n_beats", 32'(rd_log.size()), 32'd1);
        check_eq("rst_beat", rd_log[0], 32'hCAFE_F00D);

        check_eq("protocol_ops", 32'(bad_op), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
